// File: rtl/barrel_shift_sequencer_pkg.sv
// Shared types for the barrel shift sequencer: op codes, FSM states and the queued command record.
package barrel_shift_pkg;

  localparam int W     = 16;
  localparam int AMT_W = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_ROL = 2'd2,
    OP_ROR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    RSP  = 2'd3
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [W-1:0]     data;
    logic [AMT_W-1:0] amt;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic is_right(input op_e op);
    return (op == OP_SRL) || (op == OP_ROR);
  endfunction

  function automatic logic is_rotate(input op_e op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/barrel_shift_sequencer_if.sv
// Command and response handshake bundle of the barrel shift sequencer.
interface barrel_shift_sequencer_if;
  import barrel_shift_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [W-1:0]     cmd_data;
  logic [AMT_W-1:0] cmd_amt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_amt, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_amt, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/barrel_shift_sequencer_fifo.sv
// Command FIFO: registered full flag, and a new entry becomes visible to the reader
// one cycle after it is written.
module shift_cmd_fifo
  import barrel_shift_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  cmd_t                        din,
  output cmd_t                        dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;

  assign w_push      = push && !r_full;
  assign w_pop       = pop && !r_empty;
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Empty stays high for the cycle in which the count first leaves zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(FIFO_DEPTH));
      r_empty <= (r_count == '0) || (w_count_nxt == '0);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/barrel_shift_sequencer.sv
// Drives a combinational barrel shifter from queued commands; rotates take two passes
// whose results are OR-ed into the accumulator before the response is offered.
module barrel_shift_sequencer
  import barrel_shift_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  barrel_shift_sequencer_if.slave bus,
  output logic [W-1:0]            sh_i,
  output logic                    sh_dir,
  output logic [AMT_W-1:0]        sh_amt,
  input  logic [W-1:0]            sh_left,
  input  logic [W-1:0]            sh_right,
  output logic                    busy
);

  state_e                      r_state;
  state_e                      w_state_nxt;
  cmd_t                        r_cur;
  logic [W-1:0]                r_acc;
  cmd_t                        w_cmd_in;
  cmd_t                        w_fifo_dout;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                        w_pop;
  logic [W-1:0]                w_sel;

  always_comb begin
    w_cmd_in.op   = op_e'(bus.cmd_op);
    w_cmd_in.data = bus.cmd_data;
    w_cmd_in.amt  = bus.cmd_amt;
  end

  shift_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .pop   (w_pop),
    .din   (w_cmd_in),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    sh_i        = '0;
    sh_dir      = 1'b0;
    sh_amt      = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = P1;
        end
      end
      P1: begin
        sh_i        = r_cur.data;
        sh_amt      = r_cur.amt;
        sh_dir      = is_right(r_cur.op);
        w_state_nxt = (is_rotate(r_cur.op) && (r_cur.amt != '0)) ? P2 : RSP;
      end
      // Second rotate pass: opposite direction by the complementary amount (16 - amt).
      P2: begin
        sh_i        = r_cur.data;
        sh_amt      = AMT_W'(0) - r_cur.amt;
        sh_dir      = !is_right(r_cur.op);
        w_state_nxt = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = P1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_sel = sh_dir ? sh_right : sh_left;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_cur <= w_fifo_dout;
      if (r_state == P1)      r_acc <= w_sel;
      else if (r_state == P2) r_acc <= r_acc | w_sel;
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.rsp_valid = (r_state == RSP);
  assign bus.rsp_data  = r_acc;
  assign busy          = (w_count != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Bench for barrel_shift_sequencer: directed cases plus random traffic against a reference model.
module tb_barrel_shift_sequencer;
  import barrel_shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sh_i;
  logic        sh_dir;
  logic [3:0]  sh_amt;
  logic [15:0] sh_left;
  logic [15:0] sh_right;
  logic        busy;

  barrel_shift_sequencer_if bif ();

  barrel_shift_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif.slave),
    .sh_i     (sh_i),
    .sh_dir   (sh_dir),
    .sh_amt   (sh_amt),
    .sh_left  (sh_left),
    .sh_right (sh_right),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural combinational shifter.
  assign sh_left  = sh_i << sh_amt;
  assign sh_right = sh_i >> sh_amt;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          n_rsp    = 0;
  int          n_acc    = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] d,
                                             input logic [3:0] a);
    int unsigned x = d;
    int unsigned n = a;
    int unsigned r;
    case (op)
      2'd0:    r = x << n;
      2'd1:    r = x >> n;
      2'd2:    r = (n == 0) ? x : ((x << n) | (x >> (16 - n)));
      default: r = (n == 0) ? x : ((x >> n) | (x << (16 - n)));
    endcase
    return 16'(r);
  endfunction

  // Scoreboard: handshakes sampled at negedge complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.cmd_valid && bif.cmd_ready) begin
        exp_q.push_back(ref_result(bif.cmd_op, bif.cmd_data, bif.cmd_amt));
        n_acc++;
      end
      if (bif.rsp_valid && bif.rsp_ready) begin
        n_rsp++;
        check("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("rsp_data", 32'(bif.rsp_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
  task automatic push_cmd(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_data  = d;
    bif.cmd_amt   = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bif.cmd_ready) break;
    end
    check("accept_ready", 32'(bif.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
  endtask

  task automatic run_directed(input string tag, input logic [1:0] op, input logic [15:0] d,
                              input logic [3:0] a, input logic [15:0] exp_d, input int exp_lat);
    int lat = 0;
    bif.rsp_ready = 1'b1;
    push_cmd(op, d, a);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bif.rsp_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(bif.rsp_data), 32'(exp_d));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int a0;
    int budget;
    int seen;
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = '0;
    bif.cmd_data  = '0;
    bif.cmd_amt   = '0;
    bif.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bif.rsp_data),  32'd0);
    check("rst_sh_i",      32'(sh_i),          32'd0);
    check("rst_sh_amt",    32'({sh_dir, sh_amt}), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_directed("sll4",    2'd0, 16'h00F1, 4'd4,  16'h0F10, 3);
    run_directed("rol1",    2'd2, 16'h8001, 4'd1,  16'h0003, 4);
    run_directed("ror0",    2'd3, 16'h1234, 4'd0,  16'h1234, 3);
    run_directed("srl15",   2'd1, 16'hFFFF, 4'd15, 16'h0001, 3);
    run_directed("sll15",   2'd0, 16'hFFFF, 4'd15, 16'h8000, 3);
    run_directed("sll0",    2'd0, 16'hA5C3, 4'd0,  16'hA5C3, 3);
    run_directed("ror4",    2'd3, 16'h1234, 4'd4,  16'h4123, 4);

    // Backpressure: five commands, consumer stalled.
    bif.rsp_ready = 1'b0;
    r0 = n_rsp;
    push_cmd(2'd0, 16'h0001, 4'd1);
    push_cmd(2'd2, 16'hF00F, 4'd4);
    push_cmd(2'd1, 16'h8000, 4'd3);
    push_cmd(2'd3, 16'h00FF, 4'd8);
    push_cmd(2'd2, 16'h1357, 4'd0);
    check("bp_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    check("bp_busy",      32'(busy),          32'd1);
    check("bp_queued",    32'(exp_q.size()),  32'd5);
    check("bp_rsp_none",  32'(n_rsp - r0),    32'd0);
    bif.rsp_ready = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("bp_drained", 32'(n_rsp - r0), 32'd5);
    repeat (2) @(posedge clk);
    #1;
    check("bp_idle_busy", 32'(busy), 32'd0);

    // Random traffic.
    r0 = n_rsp;
    a0 = n_acc;
    budget = 0;
    while (budget < 20000) begin
      @(posedge clk);
      #1;
      budget++;
      if (n_acc - a0 >= 1000) break;
      bif.cmd_valid = ($urandom_range(0, 9) < 7);
      bif.cmd_op    = 2'($urandom_range(0, 3));
      bif.cmd_data  = 16'($urandom);
      bif.cmd_amt   = 4'($urandom_range(0, 15));
      bif.rsp_ready = ($urandom_range(0, 9) < 8);
    end
    bif.cmd_valid = 1'b0;
    bif.rsp_ready = 1'b1;
    check("rand_accepted", 32'(n_acc - a0), 32'd1000);
    budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("rand_rsp_count", 32'(n_rsp - r0), 32'd1000);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a rotate is in its second pass with two commands queued.
    bif.rsp_ready = 1'b0;
    push_cmd(2'd2, 16'h00F0, 4'd3);
    push_cmd(2'd0, 16'h0001, 4'd2);
    push_cmd(2'd1, 16'h0100, 4'd1);
    @(posedge clk);
    #1;
    check("p2_sh_dir", 32'(sh_dir), 32'd1);
    check("p2_sh_amt", 32'(sh_amt), 32'd13);
    check("p2_sh_i",   32'(sh_i),   32'h00F0);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("midrst_busy",      32'(busy),          32'd0);
    check("midrst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    check("midrst_rsp_data",  32'(bif.rsp_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bif.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bif.rsp_valid || busy) seen++;
    end
    check("midrst_no_stale", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
